// File: rtl/ram_pkg.sv
// ram_pkg: shared constants, lane count and byte-merge helper for the block RAM family
package ram_pkg;
  localparam int RDW_NO_CHANGE = 0;
  localparam int RDW_READ_FIRST = 1;
  localparam int RDW_WRITE_FIRST = 2;
  localparam int MAX_W = 1024;
  localparam int MAX_B = 128;
  function automatic int num_bytes(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w, input logic [MAX_W-1:0] new_w, input logic [MAX_B-1:0] be, input int byte_w);
    logic [MAX_W-1:0] lane;
    logic [MAX_W-1:0] m;
    logic [MAX_B-1:0] rem;
    lane = (MAX_W'(1) << byte_w) - MAX_W'(1);
    m = '0;
    rem = be;
    for (int i = 0; i < MAX_B; i++) begin
      if (rem[0]) m = m | (lane << (i * byte_w));
      rem = rem >> 1;
    end
    return (old_w & ~m) | (new_w & m);
  endfunction
endpackage

// File: rtl/dual_port_bram_if.sv
// dual_port_bram_if: port A read/write bundle and port B read bundle for dual_port_bram
interface dual_port_bram_if
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDRESS_WIDTH = 12
);
  localparam int NB = num_bytes(DATA_WIDTH, BYTE_WIDTH);
  logic a_en;
  logic [NB-1:0] a_wEn;
  logic [ADDRESS_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_dataIn;
  logic [DATA_WIDTH-1:0] a_dataOut;
  logic a_valid;
  logic b_en;
  logic [ADDRESS_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_dataOut;
  logic b_valid;
  logic collision;
  modport master (
    output a_en, a_wEn, a_addr, a_dataIn, b_en, b_addr,
    input a_dataOut, a_valid, b_dataOut, b_valid, collision
  );
  modport slave (
    input a_en, a_wEn, a_addr, a_dataIn, b_en, b_addr,
    output a_dataOut, a_valid, b_dataOut, b_valid, collision
  );
endinterface

// File: rtl/ram_out_stage.sv
// ram_out_stage: optional registered output (data + valid) with synchronous active-low clear
module ram_out_stage #(
  parameter int W = 32,
  parameter int OUT_REG = 0
) (
  input logic clk,
  input logic reset_n,
  input logic [W-1:0] d,
  input logic v,
  output logic [W-1:0] q,
  output logic qv
);
  logic [W-1:0] d_r;
  logic v_r;
  always_ff @(posedge clk) begin
    d_r <= reset_n ? d : '0;
    v_r <= reset_n && v;
  end
  assign q = OUT_REG != 0 ? d_r : d;
  assign qv = OUT_REG != 0 ? v_r : v;
endmodule

// File: rtl/dual_port_bram.sv
// dual_port_bram: shared-clock RAM, port A read/write with byte enables, port B read-only
module dual_port_bram
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH = 4096,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG = 0,
  parameter string MEMFILE = ""
) (
  input logic clk,
  input logic reset_n,
  dual_port_bram_if.slave bus
);
  localparam logic [ADDRESS_WIDTH:0] LIM = (ADDRESS_WIDTH + 1)'(DEPTH);
  if (DATA_WIDTH % BYTE_WIDTH != 0 || $clog2(DEPTH) > ADDRESS_WIDTH || RDW_MODE > 2) begin : g_bad
    $error("dual_port_bram: illegal parameter combination");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  logic a_in, b_in, a_wr, a_take;
  logic [DATA_WIDTH-1:0] a_old, b_old, a_new;
  always_comb begin
    a_in = {1'b0, bus.a_addr} < LIM;
    b_in = {1'b0, bus.b_addr} < LIM;
    a_wr = bus.a_en && |bus.a_wEn;
    a_take = bus.a_en && !(a_wr && RDW_MODE == RDW_NO_CHANGE);
    a_old = a_in ? mem[bus.a_addr] : '0;
    b_old = b_in ? mem[bus.b_addr] : '0;
    a_new = DATA_WIDTH'(byte_merge(MAX_W'(a_old), MAX_W'(bus.a_dataIn), MAX_B'(bus.a_wEn), BYTE_WIDTH));
  end
  always_ff @(posedge clk) if (reset_n && a_wr && a_in) mem[bus.a_addr] <= a_new;
  logic [DATA_WIDTH-1:0] a_d, b_d;
  logic a_v, b_v, b_col;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_d <= '0;
      a_v <= 1'b0;
      b_d <= '0;
      b_v <= 1'b0;
      b_col <= 1'b0;
    end else begin
      a_v <= a_take;
      if (a_take) a_d <= (a_wr && a_in && RDW_MODE == RDW_WRITE_FIRST) ? a_new : a_old;
      b_v <= bus.b_en;
      if (bus.b_en) b_d <= b_old;
      b_col <= bus.b_en && a_wr && a_in && bus.a_addr == bus.b_addr;
    end
  end
  logic [DATA_WIDTH:0] b_q;
  ram_out_stage #(.W(DATA_WIDTH), .OUT_REG(OUT_REG)) u_a (
    .clk(clk), .reset_n(reset_n), .d(a_d), .v(a_v), .q(bus.a_dataOut), .qv(bus.a_valid)
  );
  ram_out_stage #(.W(DATA_WIDTH + 1), .OUT_REG(OUT_REG)) u_b (
    .clk(clk), .reset_n(reset_n), .d({b_col, b_d}), .v(b_v), .q(b_q), .qv(bus.b_valid)
  );
  assign {bus.collision, bus.b_dataOut} = b_q;
endmodule
